// File: rtl/float_pack.sv
// Custom-format float type, truncating add/sub/mul/div helpers, and the
// coprocessor opcode/state enums shared by the controller and its register file.
package float_pack;

    localparam int unsigned Ne   = 8;
    localparam int unsigned Nm   = 23;
    localparam int unsigned W    = 1 + Ne + Nm;
    localparam int unsigned PW   = 2 * Nm + 2;
    localparam int          BIAS = (1 << (Ne - 1)) - 1;
    localparam int          EMAX = (1 << Ne) - 1;

    typedef struct packed {
        logic          s;
        logic [Ne-1:0] e;
        logic [Nm-1:0] m;
    } float_t;

    typedef enum logic [2:0] {
        OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_LOAD, OP_STORE, OP_NOP0, OP_NOP1
    } copro_op_t;

    typedef enum logic [1:0] {IDLE, EXEC, WB, OUT} copro_state_t;

    // e==0 encodes zero; overflow saturates to the largest finite value
    function automatic float_t float_norm(input logic sgn, input int ex, input logic [Nm-1:0] man);
        float_t r;
        if (ex <= 0)
            r = '0;
        else if (ex >= EMAX)
            r = '{s: sgn, e: Ne'(EMAX - 1), m: '1};
        else
            r = '{s: sgn, e: Ne'(ex), m: man};
        return r;
    endfunction

    function automatic float_t float_add(input float_t a, input float_t b);
        float_t        x, y;
        logic [Nm+1:0] mx, my, sum;
        int            d, ex;
        if (a.e == '0) return b;
        if (b.e == '0) return a;
        if ({a.e, a.m} >= {b.e, b.m}) begin
            x = a; y = b;
        end else begin
            x = b; y = a;
        end
        d   = int'(x.e) - int'(y.e);
        mx  = {2'b01, x.m};
        my  = {2'b01, y.m};
        my  = (d > int'(Nm) + 1) ? '0 : (my >> d);
        sum = (x.s == y.s) ? (mx + my) : (mx - my);
        if (sum == '0) return '0;
        ex = int'(x.e);
        if (sum[Nm+1]) return float_norm(x.s, ex + 1, Nm'(sum >> 1));
        for (int i = 0; i < int'(Nm); i++) begin
            if (!sum[Nm]) begin
                sum = sum << 1;
                ex  = ex - 1;
            end
        end
        return float_norm(x.s, ex, Nm'(sum));
    endfunction

    function automatic float_t float_sub(input float_t a, input float_t b);
        return float_add(a, '{s: ~b.s, e: b.e, m: b.m});
    endfunction

    function automatic float_t float_mul(input float_t a, input float_t b);
        logic [PW-1:0] p;
        int            ex;
        if (a.e == '0 || b.e == '0) return '0;
        p  = PW'({1'b1, a.m}) * PW'({1'b1, b.m});
        ex = int'(a.e) + int'(b.e) - BIAS;
        if (p[PW-1]) return float_norm(a.s ^ b.s, ex + 1, Nm'(p >> (Nm + 1)));
        return float_norm(a.s ^ b.s, ex, Nm'(p >> Nm));
    endfunction

    // divide by zero yields NaN: e all ones, m zero
    function automatic float_t float_div(input float_t a, input float_t b);
        logic [PW-1:0] q;
        int            ex;
        if (b.e == '0) return '{s: a.s ^ b.s, e: '1, m: '0};
        if (a.e == '0) return '0;
        q  = {1'b1, a.m, {(Nm + 1){1'b0}}} / PW'({1'b1, b.m});
        ex = int'(a.e) - int'(b.e) + BIAS;
        if (q[Nm+1]) return float_norm(a.s ^ b.s, ex, Nm'(q >> 1));
        return float_norm(a.s ^ b.s, ex - 1, Nm'(q));
    endfunction

endpackage

// File: rtl/float_copro_ctrl_regfile.sv
// Float register file: two asynchronous read ports, one synchronous write port.
module float_regfile
    import float_pack::*;
#(
    parameter  int unsigned NREG = 8,
    localparam int unsigned RW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_we,
    input  logic [RW-1:0] i_waddr,
    input  float_t        i_wdata,
    input  logic [RW-1:0] i_raddr_a,
    input  logic [RW-1:0] i_raddr_b,
    output float_t        o_rdata_a_c,
    output float_t        o_rdata_b_c
);

    float_t r_mem [NREG];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NREG); i++) r_mem[i] <= '0;
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a_c = r_mem[i_raddr_a];
    assign o_rdata_b_c = r_mem[i_raddr_b];

endmodule

// File: rtl/float_copro_ctrl.sv
// Floating-point coprocessor controller: one command at a time, latency-modelled
// arithmetic on snapshotted operands, STORE results on a valid/ready stream.
module float_copro_ctrl
    import float_pack::*;
#(
    parameter  int unsigned NREG    = 8,
    parameter  int unsigned LAT_ADD = 1,
    parameter  int unsigned LAT_MUL = 2,
    parameter  int unsigned LAT_DIV = 8,
    localparam int unsigned RW      = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_cmd_valid,
    output logic          o_cmd_ready,
    input  logic [2:0]    i_cmd_op,
    input  logic [RW-1:0] i_cmd_rd,
    input  logic [RW-1:0] i_cmd_ra,
    input  logic [RW-1:0] i_cmd_rb,
    input  logic [W-1:0]  i_cmd_imm,
    output logic          o_res_valid,
    input  logic          i_res_ready,
    output logic [W-1:0]  o_res_data,
    output logic [RW-1:0] o_res_reg,
    output logic          o_busy,
    output logic          o_err_dz
);

    localparam int unsigned CW = $clog2(LAT_ADD + LAT_MUL + LAT_DIV + 1);

    copro_state_t  r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    copro_op_t     r_op, w_op;
    logic [RW-1:0] r_rd, r_res_reg;
    float_t        r_a, r_b, r_imm, r_res_data, w_result, w_rdata_a_c, w_rdata_b_c;
    logic          r_cmd_ready, r_res_valid, r_busy, r_err_dz;
    logic          w_accept, w_err_dz_nxt;

    float_regfile #(.NREG(NREG)) u_regfile (
        .clk         (clk),
        .reset       (reset),
        .i_we        (r_state == WB),
        .i_waddr     (r_rd),
        .i_wdata     (w_result),
        .i_raddr_a   (i_cmd_ra),
        .i_raddr_b   (i_cmd_rb),
        .o_rdata_a_c (w_rdata_a_c),
        .o_rdata_b_c (w_rdata_b_c)
    );

    assign w_op         = copro_op_t'(i_cmd_op);
    assign w_accept     = (r_state == IDLE) && i_cmd_valid;
    assign w_err_dz_nxt = (r_state == EXEC) && (w_state_nxt == WB) &&
                          (r_op == OP_DIV) && (r_b.e == '0);

    // next state and execute countdown
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            IDLE: begin
                if (i_cmd_valid) begin
                    case (w_op)
                        OP_ADD, OP_SUB: begin
                            w_state_nxt = EXEC;
                            w_cnt_nxt   = CW'(LAT_ADD - 1);
                        end
                        OP_MUL: begin
                            w_state_nxt = EXEC;
                            w_cnt_nxt   = CW'(LAT_MUL - 1);
                        end
                        OP_DIV: begin
                            w_state_nxt = EXEC;
                            w_cnt_nxt   = CW'(LAT_DIV - 1);
                        end
                        OP_LOAD:  w_state_nxt = WB;
                        OP_STORE: w_state_nxt = OUT;
                        default:  w_state_nxt = IDLE;
                    endcase
                end
            end
            EXEC: begin
                if (r_cnt == '0) w_state_nxt = WB;
                else             w_cnt_nxt   = r_cnt - CW'(1);
            end
            WB:      w_state_nxt = IDLE;
            OUT:     if (i_res_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // writeback value; LOAD falls through to the immediate
    always_comb begin
        w_result = r_imm;
        case (r_op)
            OP_ADD:  w_result = float_add(r_a, r_b);
            OP_SUB:  w_result = float_sub(r_a, r_b);
            OP_MUL:  w_result = float_mul(r_a, r_b);
            OP_DIV:  w_result = float_div(r_a, r_b);
            default: w_result = r_imm;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_op        <= OP_NOP0;
            r_rd        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_imm       <= '0;
            r_cmd_ready <= 1'b1;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_reg   <= '0;
            r_busy      <= 1'b0;
            r_err_dz    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_cmd_ready <= (w_state_nxt == IDLE);
            r_busy      <= (w_state_nxt != IDLE);
            r_res_valid <= (w_state_nxt == OUT);
            r_err_dz    <= w_err_dz_nxt;
            if (w_accept) begin
                r_op  <= w_op;
                r_rd  <= i_cmd_rd;
                r_a   <= w_rdata_a_c;
                r_b   <= w_rdata_b_c;
                r_imm <= float_t'(i_cmd_imm);
                if (w_op == OP_STORE) begin
                    r_res_data <= w_rdata_a_c;
                    r_res_reg  <= i_cmd_ra;
                end
            end
        end
    end

    assign o_cmd_ready = r_cmd_ready;
    assign o_res_valid = r_res_valid;
    assign o_res_data  = r_res_data;
    assign o_res_reg   = r_res_reg;
    assign o_busy      = r_busy;
    assign o_err_dz    = r_err_dz;

endmodule

// File: tb/tb_float_copro_ctrl.sv
// Bench for float_copro_ctrl: transaction-level model (register array plus
// pending write/result bookkeeping) compared every cycle, plus literal anchors.
module tb_float_copro_ctrl;
    import float_pack::*;

    localparam int NREG    = 8;
    localparam int RW      = 3;
    localparam int LAT_ADD = 1;
    localparam int LAT_MUL = 2;
    localparam int LAT_DIV = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid, cmd_ready;
    logic [2:0]    cmd_op;
    logic [RW-1:0] cmd_rd, cmd_ra, cmd_rb;
    logic [W-1:0]  cmd_imm;
    logic          res_valid, res_ready;
    logic [W-1:0]  res_data;
    logic [RW-1:0] res_reg;
    logic          busy, err_dz;

    float_copro_ctrl #(.NREG(NREG), .LAT_ADD(LAT_ADD), .LAT_MUL(LAT_MUL), .LAT_DIV(LAT_DIV)) dut (
        .clk(clk), .reset(reset),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_op(cmd_op),
        .i_cmd_rd(cmd_rd), .i_cmd_ra(cmd_ra), .i_cmd_rb(cmd_rb), .i_cmd_imm(cmd_imm),
        .o_res_valid(res_valid), .i_res_ready(res_ready), .o_res_data(res_data),
        .o_res_reg(res_reg), .o_busy(busy), .o_err_dz(err_dz)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    int n_acc = 0, n_xfer_exp = 0, n_xfer_dut = 0;
    bit chk_en = 0, rr_rand = 0;

    // model state
    float_t        m_regs [NREG];
    int            m_wr_cnt = 0;
    int            m_wr_rd = 0;
    float_t        m_wr_val;
    bit            m_err = 0;
    bit            m_out = 0;
    float_t        m_out_data;
    logic [RW-1:0] m_out_reg;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    endtask

    function automatic int lat_of(input int op);
        return (op == 2) ? LAT_MUL : (op == 3) ? LAT_DIV : LAT_ADD;
    endfunction

    // model advances on every edge from the inputs the bench drove
    always @(posedge clk) begin
        if (reset) begin
            m_wr_cnt = 0; m_err = 0; m_out = 0;
            for (int i = 0; i < NREG; i++) m_regs[i] = '0;
        end else if (m_wr_cnt > 0) begin
            m_wr_cnt--;
            if (m_wr_cnt == 0) m_regs[m_wr_rd] = m_wr_val;
        end else if (m_out) begin
            if (res_ready) begin m_out = 0; n_xfer_exp++; end
        end else if (cmd_valid) begin
            n_acc++;
            m_err = 0;
            m_wr_rd = int'(cmd_rd);
            case (int'(cmd_op))
                0: m_wr_val = float_add(m_regs[cmd_ra], m_regs[cmd_rb]);
                1: m_wr_val = float_sub(m_regs[cmd_ra], m_regs[cmd_rb]);
                2: m_wr_val = float_mul(m_regs[cmd_ra], m_regs[cmd_rb]);
                3: begin
                    m_wr_val = float_div(m_regs[cmd_ra], m_regs[cmd_rb]);
                    m_err = (m_regs[cmd_rb].e == '0);
                end
                4: m_wr_val = float_t'(cmd_imm);
                default: ;
            endcase
            if (cmd_op <= 3'd3) m_wr_cnt = lat_of(int'(cmd_op)) + 1;
            else if (cmd_op == 3'd4) m_wr_cnt = 1;
            else if (cmd_op == 3'd5) begin
                m_out = 1; m_out_data = m_regs[cmd_ra]; m_out_reg = cmd_ra;
            end
        end
        if (!reset && res_valid && res_ready) n_xfer_dut++;
    end

    // every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        logic exp_rdy;
        logic [63:0] exp_v, act_v;
        if (chk_en) begin
            exp_rdy = (m_wr_cnt == 0) && !m_out;
            exp_v = 64'({exp_rdy, !exp_rdy, m_out, (m_wr_cnt == 1) && m_err,
                         m_out ? m_out_data : float_t'('0), m_out ? m_out_reg : RW'(0)});
            act_v = 64'({cmd_ready, busy, res_valid, err_dz,
                         m_out ? res_data : W'(0), m_out ? res_reg : RW'(0)});
            chk("cycle", act_v, exp_v);
        end
    end

    always @(posedge clk) if (rr_rand) #1 res_ready = 1'($urandom_range(0, 1));

    task automatic send(input int op, input int rd, input int ra, input int rb, input logic [W-1:0] imm);
        int n0;
        n0 = n_acc;
        cmd_op = 3'(op); cmd_rd = RW'(rd); cmd_ra = RW'(ra); cmd_rb = RW'(rb); cmd_imm = imm;
        cmd_valid = 1'b1;
        for (int k = 0; k < 200 && n_acc == n0; k++) begin
            @(posedge clk); #1;
        end
        if (n_acc == n0) chk("accept_timeout", 64'(n_acc), 64'(n0 + 1));
        cmd_valid = 1'b0;
    endtask

    task automatic arith(input string name, input int op, input int rd, input int ra, input int rb, input int exp_err);
        int low, errs;
        low = 0; errs = 0;
        send(op, rd, ra, rb, '0);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (cmd_ready) break;
            low++;
            if (err_dz) errs++;
        end
        chk({name, "_busy_cycles"}, 64'(low), 64'(lat_of(op) + 1));
        chk({name, "_err_dz"}, 64'(errs), 64'(exp_err));
    endtask

    task automatic store(input string name, input int ra, input logic [W-1:0] exp, input logic [W-1:0] mask);
        send(5, 0, ra, 0, '0);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (res_valid) break;
        end
        chk(name, 64'({res_valid, res_reg, res_data & mask}), 64'({1'b1, RW'(ra), exp & mask}));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1; cmd_valid = 0; cmd_op = '0; cmd_rd = '0; cmd_ra = '0; cmd_rb = '0;
        cmd_imm = '0; res_ready = 1;
        @(posedge clk); #1; chk_en = 1;
        @(negedge clk);
        chk("reset_state", 64'({cmd_ready, busy, res_valid, err_dz, res_data, res_reg}),
            64'({1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 3'h0}));
        @(posedge clk); #1; reset = 0;

        // 1: loads, multiply, store
        send(4, 1, 0, 0, 32'h3FC00000);
        send(4, 2, 0, 0, 32'h40000000);
        arith("mul", 2, 3, 1, 2, 0);
        chk("model_mul", 64'(m_regs[3]), 64'(32'h40400000));
        store("store_r3", 3, 32'h40400000, '1);

        // 2: add, sub, div
        arith("add", 0, 4, 1, 2, 0);
        arith("sub", 1, 5, 1, 2, 0);
        arith("div", 3, 6, 1, 2, 0);
        store("store_r4", 4, 32'h40600000, '1);
        store("store_r5", 5, 32'hBF000000, '1);
        store("store_r6", 6, 32'h3F400000, '1);

        // 3: divide by zero register, then rd==ra
        arith("divz", 3, 7, 1, 0, 1);
        store("store_r7_nan", 7, 32'h7F800000, 32'h7FFFFFFF);
        arith("mul_self", 2, 1, 1, 1, 0);
        store("store_r1", 1, 32'h40100000, '1);

        // 4: result back-pressure
        @(negedge clk); res_ready = 0;
        @(posedge clk); #1;
        send(5, 0, 2, 0, '0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("hold", 64'({res_valid, cmd_ready, res_reg, res_data}), 64'({1'b1, 1'b0, 3'd2, 32'h40000000}));
        end
        res_ready = 1;
        @(negedge clk);
        chk("release", 64'({res_valid, cmd_ready}), 64'({1'b0, 1'b1}));
        @(posedge clk); #1;
        send(4, 0, 0, 0, 32'h0);

        // 5: reset in the middle of a divide
        send(3, 6, 1, 0, '0);
        repeat (4) @(posedge clk);
        #1 reset = 1;
        @(posedge clk); #1 reset = 0;
        @(negedge clk);
        chk("reset_abort", 64'({cmd_ready, busy, res_valid, err_dz, res_data, res_reg}),
            64'({1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 3'h0}));
        @(posedge clk); #1;
        store("store_after_reset", 6, 32'h0, '1);

        // 6: random stream
        @(posedge clk); #1; rr_rand = 1;
        for (int n = 0; n < 2000; n++) begin
            logic [W-1:0] imm;
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            if ($urandom_range(0, 1) == 0) imm = $urandom;
            else imm = {1'($urandom_range(0, 1)), 8'(120 + $urandom_range(0, 15)), 23'($urandom)};
            send($urandom_range(0, 7), $urandom_range(0, NREG - 1), $urandom_range(0, NREG - 1),
                 $urandom_range(0, NREG - 1), imm);
        end
        for (int r = 0; r < NREG; r++) send(5, 0, r, 0, '0);
        for (int k = 0; k < 200 && m_out; k++) begin @(posedge clk); #1; end
        rr_rand = 0;
        #2;
        res_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("xfer_count", 64'(n_xfer_dut), 64'(n_xfer_exp));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/float_copro_ctrl.md
Name: float_copro_ctrl

Overview:
Sequential front-end and execution controller of the floating-point coprocessor. It accepts one command at a time over a valid/ready handshake and holds a small register file of custom-format floats. Arithmetic is issued to the shared float_pack functions float_add, float_sub, float_mul and float_div, with a programmable per-operation latency that models pipelined hardware. Register contents are returned on a valid/ready result stream.

Parameters:
NREG, 8, number of float registers (power of 2, 2..16); RW = $clog2(NREG)
LAT_ADD, 1, execute cycles for ADD/SUB (>=1)
LAT_MUL, 2, execute cycles for MUL (>=1)
LAT_DIV, 8, execute cycles for DIV (>=1)
W (localparam), 1+Ne+Nm, float width taken from float_pack

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when valid&ready
cmd_op  in  3  opcode: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 LOAD, 5 STORE, 6-7 NOP
cmd_rd  in  RW  destination register
cmd_ra  in  RW  operand A / STORE source
cmd_rb  in  RW  operand B
cmd_imm  in  W  LOAD immediate (float type)
res_valid  out  1  result word valid
res_ready  in  1  consumer accepts result
res_data  out  W  STORE data
res_reg  out  RW  register index of res_data
busy  out  1  state != IDLE
err_dz  out  1  one-cycle pulse: DIV with b.e==0 written back

Behaviour:
- Reset (synchronous, active-high): all registers = 0; state IDLE; cmd_ready=1; res_valid=0; res_data=0; res_reg=0; busy=0; err_dz=0. Reset asserted mid-operation aborts it: no writeback, no result, nothing pending.
- FSM states: IDLE, EXEC, WB, OUT.
- IDLE: cmd_ready=1. On accept, latch op, rd, ra, rb, imm and snapshot regs[ra], regs[rb] in the same edge. The operand snapshot makes rd==ra/rb safe.
  - ADD/SUB/MUL/DIV -> EXEC, counter = LAT_x-1.
  - LOAD -> WB.
  - STORE -> OUT.
  - NOP -> stay in IDLE; no effect.
- EXEC: counter decrements each cycle; at 0 -> WB. Result is computed combinationally from the snapshots with the float_pack function. It may be registered anywhere inside EXEC, but must be stable by WB.
- WB (1 cycle): regs[rd] <= result (or imm for LOAD). err_dz=1 this cycle iff op==DIV and snapshot b.e==0; the divide result is the package NaN encoding (e all ones, m=0). Then -> IDLE.
- Latency: for an arithmetic command accepted at edge t, the write occurs at edge t+LAT_x+1. The next command can be accepted at edge t+LAT_x+2. LOAD writes at t+1.
- OUT: res_valid=1, res_data=snapshot A, res_reg=ra. Data is held stable until res_valid&res_ready; at that edge -> IDLE and res_valid drops. A STORE accepted at t presents res_valid from t+1.
- cmd_ready=0 in EXEC/WB/OUT; cmd_valid is ignored there and commands are never lost. The upstream keeps the command asserted.
- No internal overflow handling: saturation and underflow-to-zero come solely from the float_pack functions.
- Register writes happen only in WB; no reads or writes outside the accept and WB edges.

Decomposition:
- float_pack additions:
  - typedef enum logic [2:0] copro_op_t {OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_LOAD, OP_STORE, OP_NOP0, OP_NOP1}
  - localparam W
  - typedef enum copro_state_t {IDLE, EXEC, WB, OUT}
- Sub-module float_regfile: NREG x float, two asynchronous read ports, one synchronous write port, synchronous reset to 0.
- Datapath calls the existing package functions; no new arithmetic.

Test Plan:
All scenarios use Ne=8, Nm=23 and LAT_ADD=1, LAT_MUL=2, LAT_DIV=8, and compare against the float_pack reference functions.
1. LOAD r1=0x3FC00000 (1.5), LOAD r2=0x40000000 (2.0), MUL r3=r1*r2, STORE r3 -> res_data=0x40400000, res_reg=3; write edge 3 cycles after MUL accept.
2. ADD r4=r1+r2, SUB r5=r1-r2, DIV r6=r1/r2, STORE r4/r5/r6 -> 0x40600000, 0xBF000000, 0x3F400000. Check cmd_ready is low for exactly LAT_x+1 cycles after each accept.
3. DIV r7=r1/r0 (r0=0 after reset) -> err_dz pulses one cycle; STORE r7 gives e=0xFF, m=0. Then MUL r1=r1*r1 (rd==ra) -> STORE r1 = 0x40100000 (2.25).
4. STORE r2 with res_ready low for 5 cycles -> res_valid/res_data (0x40000000) held stable and cmd_ready=0. Raise res_ready -> transfer, IDLE on the next cycle, next command accepted.
5. Issue DIV, assert reset at EXEC count 3 -> the next cycle shows all outputs at reset values. STORE rd afterwards returns 0x00000000 and err_dz never pulses.
6. Random 2000-command stream with random cmd_valid/res_ready gaps -> a scoreboard model of the register file matches every STORE, no command is dropped or duplicated, and NOP leaves all state unchanged.
